out_port_fifo: RTL

- Downstream of the control unit's OUT instruction path: buffers 16-bit words written when the control unit pulses output_valid.
- Presents the words to an external consumer over a valid/ready handshake.
- Decouples single-cycle EXECUTE pulses from a slow or stalling consumer.
- Reports occupancy and a sticky overflow flag to the core.

---
 rtl/out_port_fifo_pkg.sv | 10 +
 rtl/fifo_ram.sv | 22 ++
 rtl/out_port_fifo.sv | 96 +++++++++
 3 files changed

// File: rtl/out_port_fifo_pkg.sv
// Shared constants for the OUT-port word buffer: default geometry and head-stage states.
package out_port_fifo_pkg;

  localparam int unsigned OUT_FIFO_DEPTH  = 8;
  localparam int unsigned OUT_FIFO_DATA_W = 16;

  localparam logic [0:0] HEAD_EMPTY = 1'b0;
  localparam logic [0:0] HEAD_FULL  = 1'b1;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W register array: synchronous write, combinational read.
module fifo_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/out_port_fifo.sv
// OUT-port word FIFO with a registered head stage, occupancy and sticky overflow.
module out_port_fifo
  import out_port_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = OUT_FIFO_DATA_W,
  parameter int unsigned DEPTH  = OUT_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  input  logic                         clr_overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]  wptr, rptr, wptr_nxt, rptr_nxt, raddr;
  logic [CNT_W-1:0]  count_nxt;
  logic [0:0]        head_state, head_nxt;
  logic              pop, push_ok, load, ovf_nxt;
  logic [DATA_W-1:0] rdata;

  fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wptr),
    .wdata (wr_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  // The head word stays in storage at rptr until popped, so a reload reads rptr+1.
  always_comb begin
    pop       = out_valid & out_ready;
    push_ok   = wr_en & (~full | pop);
    wptr_nxt  = push_ok ? wptr + PTR_W'(1) : wptr;
    rptr_nxt  = pop ? rptr + PTR_W'(1) : rptr;
    count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop);
    ovf_nxt   = overflow;
    head_nxt  = head_state;
    load      = 1'b0;
    raddr     = (head_state == HEAD_FULL) ? rptr + PTR_W'(1) : rptr;

    if (wr_en && full && !pop) ovf_nxt = 1'b1;
    else if (clr_overflow)     ovf_nxt = 1'b0;

    case (head_state)
      HEAD_EMPTY: begin
        if (count != '0) begin
          head_nxt = HEAD_FULL;
          load     = 1'b1;
        end
      end
      HEAD_FULL: begin
        if (pop) begin
          if (count >= CNT_W'(2)) load     = 1'b1;
          else                    head_nxt = HEAD_EMPTY;
        end
      end
      default: head_nxt = HEAD_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      head_state <= HEAD_EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      wptr       <= wptr_nxt;
      rptr       <= rptr_nxt;
      count      <= count_nxt;
      head_state <= head_nxt;
      out_valid  <= (head_nxt == HEAD_FULL);
      if (load) out_data <= rdata;
      full       <= (count_nxt == CNT_W'(DEPTH));
      empty      <= (count_nxt == '0);
      overflow   <= ovf_nxt;
    end
  end

endmodule
